adc_control: RTL and testbench

Dual-channel serial ADC front end for the linear optical sensor path. On every rising edge of the sensor pixel clock it runs one 16-bit SPI-style frame on two ADCs that share clock and chip select, and deserializes the 12-bit results to parallel words. It also counts pixels per scan and flags scan completion to the downstream sample processor.

---
 rtl/adc_control.sv | 248 ++++++++++++++++++++++++
 tb/tb_adc_control.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_control.sv
// adc_control: dual-channel serial ADC front end.
// Each synchronized sensor_clk rising edge runs one 16-bit frame on two ADCs
// that share ADC_clk and chip_select. The low 12 bits of each frame are
// presented on pdata1/pdata2 together with a one-cycle new_Data strobe.
// Conversions are counted per scan, and interrupt is raised after PIXELS of them.
// Optional feature macro: ADC_CH2_EN. When it is defined, channel 2 is captured.
// When it is not defined, Data2 is ignored and pdata2 stays at zero.
module adc_control #(
  parameter int CLK_DIV = 1,
  parameter int PIXELS  = 128
) (
  input  logic        clk_20M,
  input  logic        reset,
  input  logic        Data1,
  input  logic        Data2,
  input  logic        sensor_clk,
  input  logic        sample_control,
  output logic        ADC_clk,
  output logic        chip_select,
  output logic [11:0] pdata1,
  output logic [11:0] pdata2,
  output logic        new_Data,
  output logic        interrupt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = $clog2(PIXELS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PIXELS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Synchronizer stages: [0],[1] form the 2-flop synchronizer, [2] holds the previous value for edge detection
  logic [2:0] sclk_sync_r;
  logic [2:0] samp_sync_r;
  logic       sclk_rise_s;
  logic       samp_rise_s;

  state_t           state_r, state_nxt;
  logic             cs_r, cs_nxt;
  logic             adc_clk_r, adc_clk_nxt;
  logic [DIV_W-1:0] div_cnt_r, div_cnt_nxt;
  logic [4:0]       bit_cnt_r, bit_cnt_nxt;
  logic             sample_en_s;
  logic             load_s;
  logic             new_data_r;

  logic [15:0]      sh1_r, sh1_nxt;
  logic [11:0]      pdata1_r, pdata1_nxt;
  logic [IDX_W-1:0] index_r, index_nxt;
  logic             irq_r, irq_nxt;

  // Synchronize the asynchronous sensor inputs and keep one extra stage for edge detection
  always_ff @(posedge clk_20M or negedge reset) begin
    if (!reset) begin
      sclk_sync_r <= 3'b000;
      samp_sync_r <= 3'b000;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sensor_clk};
      samp_sync_r <= {samp_sync_r[1:0], sample_control};
    end
  end

  assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
  assign samp_rise_s = samp_sync_r[1] & ~samp_sync_r[2];

  // Frame sequencer: next state, next ADC_clk/chip_select levels, sample and load strobes
  always_comb begin
    state_nxt   = state_r;
    cs_nxt      = cs_r;
    adc_clk_nxt = adc_clk_r;
    div_cnt_nxt = div_cnt_r;
    bit_cnt_nxt = bit_cnt_r;
    sample_en_s = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        cs_nxt      = 1'b1;
        adc_clk_nxt = 1'b1;
        div_cnt_nxt = '0;
        bit_cnt_nxt = 5'd0;
        if (sclk_rise_s) begin
          // The first ADC_clk falling edge coincides with the chip_select falling edge
          state_nxt   = CONV;
          cs_nxt      = 1'b0;
          adc_clk_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      CONV: begin
        cs_nxt = 1'b0;
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (!adc_clk_r) begin
            // The low->high edge is the sampling point; data has been stable for a full half-period
            adc_clk_nxt = 1'b1;
            sample_en_s = 1'b1;
            bit_cnt_nxt = bit_cnt_r + 5'd1;
          end else if (bit_cnt_r == 5'd16) begin
            // The high half-period after the 16th sample has elapsed, so the frame ends here
            state_nxt   = DONE;
            cs_nxt      = 1'b1;
            adc_clk_nxt = 1'b1;
            load_s      = 1'b1;
          end else begin
            adc_clk_nxt = 1'b0;
          end
        end else begin
          div_cnt_nxt = div_cnt_r + DIV_W'(1);
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        cs_nxt      = 1'b1;
        adc_clk_nxt = 1'b1;
      end
      default: begin
        state_nxt   = IDLE;
        cs_nxt      = 1'b1;
        adc_clk_nxt = 1'b1;
      end
    endcase
  end

  // Channel 1 shift register and output word
  always_comb begin
    sh1_nxt    = sh1_r;
    pdata1_nxt = pdata1_r;
    if (sample_en_s) begin
      sh1_nxt = {sh1_r[14:0], Data1};
    end else begin
      sh1_nxt = sh1_r;
    end
    if (load_s) begin
      pdata1_nxt = sh1_r[11:0];
    end else begin
      pdata1_nxt = pdata1_r;
    end
  end

  // Pixel index and scan interrupt; a start-of-scan edge overrides a simultaneous increment
  always_comb begin
    index_nxt = index_r;
    irq_nxt   = irq_r;
    if (samp_rise_s) begin
      index_nxt = '0;
      irq_nxt   = 1'b0;
    end else if (load_s) begin
      if (index_r != IDX_MAX) begin
        index_nxt = index_r + IDX_W'(1);
        if (index_r == IDX_LAST) begin
          irq_nxt = 1'b1;
        end else begin
          irq_nxt = irq_r;
        end
      end else begin
        index_nxt = index_r;
        irq_nxt   = irq_r;
      end
    end else begin
      index_nxt = index_r;
      irq_nxt   = irq_r;
    end
  end

  // Register the FSM, the serial clock and chip select, channel 1 data and the pixel counter
  always_ff @(posedge clk_20M or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cs_r       <= 1'b1;
      adc_clk_r  <= 1'b1;
      div_cnt_r  <= '0;
      bit_cnt_r  <= 5'd0;
      new_data_r <= 1'b0;
      sh1_r      <= 16'h0000;
      pdata1_r   <= 12'h000;
      index_r    <= '0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      cs_r       <= cs_nxt;
      adc_clk_r  <= adc_clk_nxt;
      div_cnt_r  <= div_cnt_nxt;
      bit_cnt_r  <= bit_cnt_nxt;
      new_data_r <= load_s;
      sh1_r      <= sh1_nxt;
      pdata1_r   <= pdata1_nxt;
      index_r    <= index_nxt;
      irq_r      <= irq_nxt;
    end
  end

`ifdef ADC_CH2_EN
  logic [15:0] sh2_r, sh2_nxt;
  logic [11:0] pdata2_r, pdata2_nxt;
  logic        unused_lead_s;

  // Channel 2 shift register and output word, clocked by the same strobes as channel 1
  always_comb begin
    sh2_nxt    = sh2_r;
    pdata2_nxt = pdata2_r;
    if (sample_en_s) begin
      sh2_nxt = {sh2_r[14:0], Data2};
    end else begin
      sh2_nxt = sh2_r;
    end
    if (load_s) begin
      pdata2_nxt = sh2_r[11:0];
    end else begin
      pdata2_nxt = pdata2_r;
    end
  end

  // Register the channel 2 datapath
  always_ff @(posedge clk_20M or negedge reset) begin
    if (!reset) begin
      sh2_r    <= 16'h0000;
      pdata2_r <= 12'h000;
    end else begin
      sh2_r    <= sh2_nxt;
      pdata2_r <= pdata2_nxt;
    end
  end

  assign pdata2        = pdata2_r;
  // The oldest leading bits shift out of both registers unread
  assign unused_lead_s = sh1_r[15] ^ sh2_r[15];
`else
  logic unused_ch2_s;

  assign pdata2       = 12'h000;
  // With channel 2 disabled, Data2 and the top shift bit are not read
  assign unused_ch2_s = Data2 ^ sh1_r[15];
`endif

  assign ADC_clk     = adc_clk_r;
  assign chip_select = cs_r;
  assign pdata1      = pdata1_r;
  assign new_Data    = new_data_r;
  assign interrupt   = irq_r;

endmodule

// File: tb/tb_adc_control.sv
// Directed testbench for adc_control. It uses two instances: CLK_DIV=1 (a) and CLK_DIV=2 (b).
// Behavioural ADC models shift out 16-bit words MSB first on ADC_clk falling edges.
`timescale 1ns/1ps
module tb_adc_control;

  logic        clk_20M = 1'b0;
  logic        reset = 1'b0;
  logic        sensor_clk = 1'b0;
  logic        sample_control = 1'b0;
  logic        d1a = 1'b0, d2a = 1'b0, d1b = 1'b0, d2b = 1'b0;
  logic        adc_clk_a, cs_a, nd_a, irq_a;
  logic        adc_clk_b, cs_b, nd_b, irq_b;
  logic [11:0] pd1_a, pd2_a, pd1_b, pd2_b;

  logic [15:0] w1 = 16'h09FD;
  logic [15:0] w2 = 16'h09FD;
  logic [15:0] wb = 16'h09FD;

  int checks = 0;
  int failures = 0;
  int bp_a = 0, bp_b = 0;
  int rise_a = 0, rise_b = 0;

  // per-frame measurements
  int          lat_a, csl_a, csl_b, nstb_a, nstb_b, rd_a, rd_b;
  logic [11:0] cap_pd1_a, cap_pd2_a, cap_pd1_b, cap_pd2_b;
  logic        cap_cs_a, cap_irq_a;
  int          scan_stb;

  always #25 clk_20M = ~clk_20M;

  adc_control #(.CLK_DIV(1), .PIXELS(128)) u_dut_a (
    .clk_20M(clk_20M), .reset(reset), .Data1(d1a), .Data2(d2a),
    .sensor_clk(sensor_clk), .sample_control(sample_control),
    .ADC_clk(adc_clk_a), .chip_select(cs_a), .pdata1(pd1_a), .pdata2(pd2_a),
    .new_Data(nd_a), .interrupt(irq_a)
  );

  adc_control #(.CLK_DIV(2), .PIXELS(128)) u_dut_b (
    .clk_20M(clk_20M), .reset(reset), .Data1(d1b), .Data2(d2b),
    .sensor_clk(sensor_clk), .sample_control(sample_control),
    .ADC_clk(adc_clk_b), .chip_select(cs_b), .pdata1(pd1_b), .pdata2(pd2_b),
    .new_Data(nd_b), .interrupt(irq_b)
  );

  // ADC model a: next bit on each falling ADC_clk while selected, rewind on deselect
  always @(negedge adc_clk_a or posedge cs_a) begin
    #1;
    if (cs_a) bp_a = 0;
    else if (bp_a < 16) begin
      d1a = w1[15-bp_a];
      d2a = w2[15-bp_a];
      bp_a = bp_a + 1;
    end
  end

  // ADC model b: fixed word on both channels
  always @(negedge adc_clk_b or posedge cs_b) begin
    #1;
    if (cs_b) bp_b = 0;
    else if (bp_b < 16) begin
      d1b = wb[15-bp_b];
      d2b = wb[15-bp_b];
      bp_b = bp_b + 1;
    end
  end

  always @(posedge adc_clk_a) rise_a = rise_a + 1;
  always @(posedge adc_clk_b) rise_b = rise_b + 1;

  function automatic logic [11:0] exp_pd2(input logic [11:0] v);
`ifdef ADC_CH2_EN
    return v;
`else
    return 12'h000;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 100-cycle (5 us) pixel slot. gap>0 adds a second sensor_clk pulse.
  // samp_at>0 adds a sample_control pulse.
  task automatic run_frame(input int gap, input int samp_at);
    int ra, rb;
    ra = rise_a; rb = rise_b;
    lat_a = 0; csl_a = 0; csl_b = 0; nstb_a = 0; nstb_b = 0;
    sensor_clk = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_20M);
      if (!cs_a) begin
        csl_a = csl_a + 1;
        if (lat_a == 0) lat_a = i;
      end
      if (!cs_b) csl_b = csl_b + 1;
      if (nd_a) begin
        nstb_a = nstb_a + 1;
        cap_pd1_a = pd1_a; cap_pd2_a = pd2_a; cap_cs_a = cs_a; cap_irq_a = irq_a;
      end
      if (nd_b) begin
        nstb_b = nstb_b + 1;
        cap_pd1_b = pd1_b; cap_pd2_b = pd2_b;
      end
      if (i == 10) sensor_clk = 1'b0;
      if (gap > 0 && i == gap) sensor_clk = 1'b1;
      if (gap > 0 && i == gap + 5) sensor_clk = 1'b0;
      if (samp_at > 0 && i == samp_at) sample_control = 1'b1;
      if (samp_at > 0 && i == samp_at + 5) sample_control = 1'b0;
    end
    rd_a = rise_a - ra;
    rd_b = rise_b - rb;
  endtask

  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      run_frame(0, 0);
      scan_stb = scan_stb + nstb_a;
    end
  endtask

  task automatic pulse_sample();
    sample_control = 1'b1;
    repeat (5) @(negedge clk_20M);
    sample_control = 1'b0;
    repeat (5) @(negedge clk_20M);
  endtask

  initial begin
    int stb;
    // reset state
    repeat (3) @(negedge clk_20M);
    check_val("rst_cs", cs_a, 1);
    check_val("rst_adc_clk", adc_clk_a, 1);
    check_val("rst_pdata1", pd1_a, 0);
    check_val("rst_pdata2", pd2_a, 0);
    check_val("rst_new_data", nd_a, 0);
    check_val("rst_irq", irq_a, 0);
    check_val("rst_cs_b", cs_b, 1);
    check_val("rst_irq_b", irq_b, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk_20M);

    // basic frame: 4 zeros then 12'h9FD on both channels
    run_frame(0, 0);
    check_val("latency", lat_a, 3);
    check_val("cs_low_cycles", csl_a, 32);
    check_val("adc_clk_rises", rd_a, 16);
    check_val("strobes", nstb_a, 1);
    check_val("cs_high_at_strobe", cap_cs_a, 1);
    check_val("pdata1_9fd", cap_pd1_a, 12'h9FD);
    check_val("pdata2_9fd", cap_pd2_a, exp_pd2(12'h9FD));
    check_val("div2_strobes", nstb_b, 1);
    check_val("div2_cs_low", csl_b, 64);
    check_val("div2_rises", rd_b, 16);
    check_val("div2_pdata1", cap_pd1_b, 12'h9FD);
    check_val("div2_pdata2", cap_pd2_b, exp_pd2(12'h9FD));

    // extreme values per channel
    w1 = 16'h0FFF; w2 = 16'h0001;
    run_frame(0, 0);
    check_val("pdata1_fff", cap_pd1_a, 12'hFFF);
    check_val("pdata2_001", cap_pd2_a, exp_pd2(12'h001));

    // non-zero leading bits are discarded
    w1 = 16'hA5C3; w2 = 16'h5A3C;
    run_frame(0, 0);
    check_val("pdata1_lead", cap_pd1_a, 12'h5C3);
    check_val("pdata2_lead", cap_pd2_a, exp_pd2(12'hA3C));

    // second sensor_clk rise during CONV is ignored
    w1 = 16'h0123; w2 = 16'h0456;
    run_frame(20, 0);
    check_val("ignore_strobes", nstb_a, 1);
    check_val("ignore_cs_low", csl_a, 32);
    check_val("ignore_pdata1", cap_pd1_a, 12'h123);

    // reset asserted mid-frame
    sensor_clk = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_20M);
      if (i == 10) sensor_clk = 1'b0;
    end
    check_val("mid_cs_low", cs_a, 0);
    reset = 1'b0;
    #1;
    check_val("mid_rst_cs", cs_a, 1);
    check_val("mid_rst_adc_clk", adc_clk_a, 1);
    check_val("mid_rst_pdata1", pd1_a, 0);
    check_val("mid_rst_pdata2", pd2_a, 0);
    check_val("mid_rst_new_data", nd_a, 0);
    repeat (5) @(negedge clk_20M);
    reset = 1'b1;
    stb = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_20M);
      if (nd_a) stb = stb + 1;
    end
    check_val("mid_rst_no_strobe", stb, 0);
    check_val("mid_rst_pdata1_hold", pd1_a, 0);

    // full scan of 128 pixels
    w1 = 16'h0ABC; w2 = 16'h0DEF;
    pulse_sample();
    check_val("scan_start_irq", irq_a, 0);
    scan_stb = 0;
    run_frames(127);
    check_val("scan_127_strobes", scan_stb, 127);
    check_val("scan_127_irq", irq_a, 0);
    run_frames(1);
    check_val("scan_128_strobes", scan_stb, 128);
    check_val("irq_in_done_128", cap_irq_a, 1);
    check_val("irq_after_128", irq_a, 1);
    run_frames(1);
    check_val("irq_saturated", irq_a, 1);
    check_val("scan_pdata1", cap_pd1_a, 12'hABC);

    // start-of-scan edge coincident with DONE increment: clear wins
    run_frame(0, 32);
    check_val("collide_strobe", nstb_a, 1);
    check_val("collide_irq_at_strobe", cap_irq_a, 0);
    check_val("collide_irq", irq_a, 0);
    scan_stb = 0;
    run_frames(127);
    check_val("rescan_127_irq", irq_a, 0);
    run_frames(1);
    check_val("rescan_128_irq", irq_a, 1);
    pulse_sample();
    check_val("irq_cleared", irq_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
